hpdmc_readbuf: RTL and testbench

- Read-data buffer directly downstream of the DDR I/O capture and directly upstream of the scheduler's `buffer_r_*` interface.
- Collects 64-bit read beats from the DDR I/O block into burst-sized slots of 4 beats each.
- Presents the head burst word-by-word on `buffer_r_dat`. The scheduler advances within a burst with `buffer_r_next` and releases the burst with `buffer_r_nextburst`.
- Decouples SDRAM read timing (CAS latency, prefetch) from WISHBONE acknowledge timing.

---
 rtl/hpdmc_readbuf.sv | 124 ++++++++++++
 tb/tb_hpdmc_readbuf.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hpdmc_readbuf.sv
// hpdmc_readbuf: collects 64-bit DDR read beats into 4-beat burst slots and
// presents the head burst word-by-word to the scheduler.
module hpdmc_readbuf #(
  parameter int slot_depth = 2,
  parameter int burst_len  = 4
) (
  input  logic        sys_clk,
  input  logic        sdram_rst_n,
  input  logic        rd_valid,
  input  logic [63:0] rd_dat,
  input  logic        flush,
  input  logic        buffer_r_next,
  input  logic        buffer_r_nextburst,
  output logic [63:0] buffer_r_dat,
  output logic        burst_ready,
  output logic        full,
  output logic        overflow,
  output logic        underflow
);

  localparam int SLOT_W = $clog2(slot_depth);
  localparam int BEAT_W = $clog2(burst_len);
  localparam int CNT_W  = $clog2(slot_depth + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(burst_len - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(slot_depth);

  // Burst storage; contents are meaningless until pointers say otherwise,
  // so no reset is needed.
  logic [63:0] mem_q [slot_depth][burst_len];

  logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
  logic [SLOT_W-1:0] rd_slot_q, rd_slot_d;
  logic [BEAT_W-1:0] wr_beat_q, wr_beat_d;
  logic [BEAT_W-1:0] rd_word_q, rd_word_d;
  logic [CNT_W-1:0]  count_q,   count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic wr_fire, burst_done, rel, have_burst;

  // Next-state: write/read pointers, burst count and sticky error flags.
  always_comb begin
    wr_slot_d   = wr_slot_q;
    rd_slot_d   = rd_slot_q;
    wr_beat_d   = wr_beat_q;
    rd_word_d   = rd_word_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    have_burst = (count_q != '0);
    // full is judged on pre-edge state, so a release in the same cycle
    // does not make room for the incoming beat.
    wr_fire    = rd_valid && (count_q != CNT_FULL);
    burst_done = wr_fire && (wr_beat_q == LAST_BEAT);
    rel        = buffer_r_nextburst && have_burst;

    if (wr_fire) begin
      wr_beat_d = wr_beat_q + BEAT_W'(1);
      if (burst_done) wr_slot_d = wr_slot_q + SLOT_W'(1);
    end

    if (rel) begin
      rd_slot_d = rd_slot_q + SLOT_W'(1);
      rd_word_d = '0;
    end else if (buffer_r_next && have_burst) begin
      rd_word_d = rd_word_q + BEAT_W'(1);
    end

    count_d = count_q + (burst_done ? CNT_W'(1) : CNT_W'(0))
                      - (rel        ? CNT_W'(1) : CNT_W'(0));

    if (rd_valid && !wr_fire)                  overflow_d  = 1'b1;
    if (buffer_r_nextburst && !have_burst)     underflow_d = 1'b1;

    // Flush discards everything in flight but keeps the error history.
    if (flush) begin
      wr_slot_d = '0;
      rd_slot_d = '0;
      wr_beat_d = '0;
      rd_word_d = '0;
      count_d   = '0;
    end
  end

  // Pointer, count and flag registers.
  always_ff @(posedge sys_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      wr_slot_q   <= '0;
      rd_slot_q   <= '0;
      wr_beat_q   <= '0;
      rd_word_q   <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_slot_q   <= wr_slot_d;
      rd_slot_q   <= rd_slot_d;
      wr_beat_q   <= wr_beat_d;
      rd_word_q   <= rd_word_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Beat capture into the slot currently being filled.
  always_ff @(posedge sys_clk) begin
    if (wr_fire && !flush) mem_q[wr_slot_q][wr_beat_q] <= rd_dat;
  end

  // Head word is read straight from the pointers; zero when nothing is held.
  always_comb begin
    buffer_r_dat = '0;
    if (count_q != '0) buffer_r_dat = mem_q[rd_slot_q][rd_word_q];
  end

  assign burst_ready = (count_q != '0);
  assign full        = (count_q == CNT_FULL);
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_hpdmc_readbuf.sv
// Directed bench for hpdmc_readbuf (slot_depth=2).
module tb_hpdmc_readbuf;

  logic        sys_clk = 1'b0;
  logic        sdram_rst_n;
  logic        rd_valid;
  logic [63:0] rd_dat;
  logic        flush;
  logic        buffer_r_next;
  logic        buffer_r_nextburst;
  logic [63:0] buffer_r_dat;
  logic        burst_ready, full, overflow, underflow;

  int n_chk  = 0;
  int n_pass = 0;

  hpdmc_readbuf #(.slot_depth(2), .burst_len(4)) dut (
    .sys_clk            (sys_clk),
    .sdram_rst_n        (sdram_rst_n),
    .rd_valid           (rd_valid),
    .rd_dat             (rd_dat),
    .flush              (flush),
    .buffer_r_next      (buffer_r_next),
    .buffer_r_nextburst (buffer_r_nextburst),
    .buffer_r_dat       (buffer_r_dat),
    .burst_ready        (burst_ready),
    .full               (full),
    .overflow           (overflow),
    .underflow          (underflow)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  // Advance one rising edge; outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d);
    rd_valid = 1'b1; rd_dat = d;
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic burst4(input logic [63:0] base);
    for (int k = 0; k < 4; k++) beat(base + 64'(k));
  endtask

  task automatic pulse_next();
    buffer_r_next = 1'b1; tick(); buffer_r_next = 1'b0;
  endtask

  task automatic pulse_nb();
    buffer_r_nextburst = 1'b1; tick(); buffer_r_nextburst = 1'b0;
  endtask

  localparam logic [63:0] B0 = 64'hB000_0000_0000_0000;
  localparam logic [63:0] C0 = 64'hC000_0000_0000_0000;
  localparam logic [63:0] D0 = 64'hD000_0000_0000_0000;
  localparam logic [63:0] E0 = 64'hE000_0000_0000_0000;
  localparam logic [63:0] G0 = 64'h6000_0000_0000_0000;
  localparam logic [63:0] F0 = 64'hF000_0000_0000_0000;
  localparam logic [63:0] H0 = 64'h4800_0000_0000_0000;
  localparam logic [63:0] K0 = 64'h4B00_0000_0000_0000;

  initial begin
    sdram_rst_n = 1'b0; rd_valid = 1'b0; rd_dat = '0; flush = 1'b0;
    buffer_r_next = 1'b0; buffer_r_nextburst = 1'b0;
    #3;
    chk("rst_ready", 64'(burst_ready), 64'd0);
    chk("rst_full",  64'(full),        64'd0);
    chk("rst_dat",   buffer_r_dat,     64'd0);
    chk("rst_ovf",   64'(overflow),    64'd0);
    chk("rst_unf",   64'(underflow),   64'd0);
    tick();
    sdram_rst_n = 1'b1;
    tick();

    // Single burst
    beat(64'h1111_1111_1111_1111);
    beat(64'h2222_2222_2222_2222);
    beat(64'h3333_3333_3333_3333);
    chk("partial_not_ready", 64'(burst_ready), 64'd0);
    beat(64'h4444_4444_4444_4444);
    chk("single_ready", 64'(burst_ready), 64'd1);
    chk("single_w0", buffer_r_dat, 64'h1111_1111_1111_1111);
    pulse_next(); chk("single_w1", buffer_r_dat, 64'h2222_2222_2222_2222);
    pulse_next(); chk("single_w2", buffer_r_dat, 64'h3333_3333_3333_3333);
    pulse_next(); chk("single_w3", buffer_r_dat, 64'h4444_4444_4444_4444);
    pulse_nb();
    chk("single_rel_ready", 64'(burst_ready), 64'd0);
    chk("single_rel_dat",   buffer_r_dat,     64'd0);

    // Fill and overflow
    burst4(B0);
    chk("fill_half_full", 64'(full), 64'd0);
    burst4(B0 + 64'd4);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_head", buffer_r_dat, B0);
    beat(64'hDEAD_BEEF_DEAD_BEEF);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_still_full", 64'(full), 64'd1);
    chk("ovf_head", buffer_r_dat, B0);
    pulse_nb();
    chk("rel_not_full", 64'(full), 64'd0);
    chk("rel_head_b5", buffer_r_dat, B0 + 64'd4);

    // Burst completion coinciding with release: count stays 1
    beat(C0); beat(C0 + 64'd1); beat(C0 + 64'd2);
    rd_valid = 1'b1; rd_dat = C0 + 64'd3; buffer_r_nextburst = 1'b1;
    tick();
    rd_valid = 1'b0; buffer_r_nextburst = 1'b0;
    chk("simul_ready", 64'(burst_ready), 64'd1);
    chk("simul_full",  64'(full),        64'd0);
    chk("simul_head",  buffer_r_dat,     C0);

    // next + nextburst together on word 2 -> new head at word 0
    burst4(D0);
    chk("prio_full", 64'(full), 64'd1);
    pulse_next(); pulse_next();
    chk("prio_w2", buffer_r_dat, C0 + 64'd2);
    buffer_r_next = 1'b1; buffer_r_nextburst = 1'b1;
    tick();
    buffer_r_next = 1'b0; buffer_r_nextburst = 1'b0;
    chk("prio_head_w0", buffer_r_dat, D0);
    chk("prio_not_full", 64'(full), 64'd0);
    pulse_nb();
    chk("prio_empty", 64'(burst_ready), 64'd0);

    // Underflow and ignored next when empty
    chk("unf_clear", 64'(underflow), 64'd0);
    pulse_nb();
    chk("unf_flag",  64'(underflow),   64'd1);
    chk("unf_empty", 64'(burst_ready), 64'd0);
    chk("unf_dat",   buffer_r_dat,     64'd0);
    pulse_next();
    burst4(E0);
    chk("ign_next_head", buffer_r_dat, E0);
    pulse_nb();

    // Async reset mid-burst
    burst4(G0);
    beat(F0); beat(F0 + 64'd1);
    chk("pre_arst_head", buffer_r_dat, G0);
    #2 sdram_rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(burst_ready), 64'd0);
    chk("arst_dat",   buffer_r_dat,     64'd0);
    chk("arst_ovf",   64'(overflow),    64'd0);
    chk("arst_unf",   64'(underflow),   64'd0);
    #3 sdram_rst_n = 1'b1;
    tick();
    burst4(H0);
    chk("post_arst_head", buffer_r_dat, H0);
    pulse_next();
    chk("post_arst_w1", buffer_r_dat, H0 + 64'd1);
    pulse_nb();

    // Flush mid-burst keeps the sticky overflow flag
    burst4(B0); burst4(C0);
    beat(64'h0BAD_0BAD_0BAD_0BAD);
    chk("fl_ovf_set", 64'(overflow), 64'd1);
    pulse_nb();
    beat(F0); beat(F0 + 64'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl_ready", 64'(burst_ready), 64'd0);
    chk("fl_full",  64'(full),        64'd0);
    chk("fl_dat",   buffer_r_dat,     64'd0);
    chk("fl_ovf_kept", 64'(overflow), 64'd1);
    burst4(K0);
    chk("post_fl_head", buffer_r_dat, K0);
    pulse_next(); pulse_next(); pulse_next();
    chk("post_fl_w3", buffer_r_dat, K0 + 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
